rv32i_multicycle_controller: RTL and testbench
==============================================

Name: rv32i_multicycle_controller

Overview:
Main control FSM for the multicycle rv32i core. It sequences the shared ALU, the single memory port, the PC/PC_old registers, the IR and the register file. Each cycle it decodes the latched instruction fields and drives mux selects, write enables and alu_control. It replaces the inline state logic in the core top and contains no datapath registers of its own.

Parameters:
none

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
ena  input  1  global enable; low freezes the FSM and forces all write enables to 0
op  input  7  ir[6:0]
funct3  input  3  ir[14:12]
funct7  input  7  ir[31:25]
alu_zero  input  1  zero flag of the current ALU result
pc_ena  output  1  load PC (PC_old loads together with it)
ir_write  output  1  latch mem_rd_data into IR
mem_wr_ena  output  1  memory write strobe
reg_write  output  1  register-file write enable
mem_src  output  1  memory address select: MEM_SRC_PC / MEM_SRC_RESULT
alu_src_a  output  2  ALU A select: SRC_A_PC / SRC_A_OLD_PC / SRC_A_REG / SRC_A_ZERO
alu_src_b  output  2  ALU B select: SRC_B_REG / SRC_B_IMM / SRC_B_FOUR
result_src  output  2  result select: RES_ALU_OUT (registered) / RES_MEM_DATA / RES_ALU_DIRECT
imm_src  output  3  immediate format: IMM_I / IMM_S / IMM_B / IMM_U / IMM_J
alu_control  output  alu_control_t  ALU operation
illegal  output  1  sticky illegal-instruction flag
state  output  4  current state, for debug and bench

Behaviour:
- Moore outputs decode combinationally from state, except alu_control, imm_src and the branch pc_ena, which also use op/funct fields.
- Unlisted outputs in every state: all enables 0, mem_src=PC, src_a=PC, src_b=FOUR, result_src=ALU_OUT, alu_control=ALU_ADD, imm_src=IMM_I.
- rst: state<=FETCH and illegal<=0 at the clock edge. While rst is high, all enables are forced to 0. Reset mid-instruction abandons the instruction; no partial writes.
- ena=0: state and illegal hold, and pc_ena, ir_write, reg_write and mem_wr_ena are forced to 0.
- FETCH: ir_write=1, pc_ena=1, result_src=ALU_DIRECT, so PC<=PC+4. Next state: DECODE.
- DECODE: src_a=OLD_PC, src_b=IMM, imm_src=B, or J for JAL. This precomputes the branch/jump target into ALU_OUT.
  - Next state by op: LOAD/STORE->MEM_ADR, RTYPE->EXECUTE_R, ITYPE->EXECUTE_I, BRANCH->BRANCH, JAL->JAL, JALR->JALR, LUI->LUI, AUIPC->AUIPC, else ERROR.
- MEM_ADR: src_a=REG, src_b=IMM, imm_src=I for load or S for store. Next state: MEM_READ (load) or MEM_WRITE (store).
- MEM_READ: mem_src=RESULT. Next state: MEM_WB.
- MEM_WB: result_src=MEM_DATA, reg_write=1. Next state: FETCH.
- MEM_WRITE: mem_src=RESULT, mem_wr_ena=1. Next state: FETCH.
- EXECUTE_R: src_a=REG, src_b=REG, alu_control from the R-type decode. Next state: ALU_WB.
- EXECUTE_I: src_a=REG, src_b=IMM, imm_src=I, alu_control from the I-type decode. funct7 is checked only for shifts. Next state: ALU_WB.
- ALU_WB: result_src=ALU_OUT, reg_write=1. Next state: FETCH.
- BRANCH: src_a=REG, src_b=REG, result_src=ALU_OUT. Next state: FETCH.
  - BEQ/BNE use ALU_SUB; BLT/BGE use ALU_SLT; BLTU/BGEU use ALU_SLTU.
  - taken: BEQ=zero, BNE=~zero, BLT/BLTU=~zero, BGE/BGEU=zero. pc_ena=taken.
- JALR: src_a=REG, src_b=IMM, imm_src=I; writes the target to ALU_OUT. Next state: JAL.
- JAL: pc_ena=1, result_src=ALU_OUT (the target); ALU computes OLD_PC+4 (src_a=OLD_PC, src_b=FOUR). Next state: ALU_WB.
- LUI: src_a=ZERO, src_b=IMM, imm_src=U. Next state: ALU_WB.
- AUIPC: src_a=OLD_PC, src_b=IMM, imm_src=U. Next state: ALU_WB.
- ERROR: illegal=1, all enables 0, absorbing until rst. An illegal funct3/funct7 combination in EXECUTE_R/I or BRANCH also transitions to ERROR, and no write occurs.
- Latency in cycles: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL 4, JALR 5.

Decomposition:
- Package rv32i_defines: state enum, mux-select enums, op/funct3/funct7 constants.
- Package alu_types: alu_control_t.
- Sub-module rv32i_alu_decoder: combinational map of (state class, funct3, funct7) to alu_control plus an illegal flag. It is instantiated once.

Test Plan:
- rst high 2 cycles, then low → state=FETCH, all enables 0 during rst, illegal=0.
- IR=0x00700093 (addi x1,x0,7) → states FETCH, DECODE, EXECUTE_I, ALU_WB; alu_control=ALU_ADD, src_b=IMM; reg_write=1 only in ALU_WB.
- IR=0x002081B3 (add x3,x1,x2) → EXECUTE_R with both srcs REG; funct7=0x20 selects ALU_SUB; funct7=0x01 → ERROR with illegal=1 and no reg_write.
- IR=0x00802203 (lw x4,8(x0)) → MEM_ADR, MEM_READ (mem_src=RESULT), MEM_WB (result_src=MEM_DATA, reg_write=1). IR=0x00102623 (sw) → mem_wr_ena=1 for exactly one cycle.
- IR=0x00000463 (beq x0,x0,8) with alu_zero=1 → pc_ena=1 in BRANCH; alu_zero=0 → pc_ena=0; next state FETCH.
- ena=0 held 3 cycles in EXECUTE_R, then op=0x7F and rst asserted mid-sequence → state frozen with no enables; opcode 0x7F → ERROR; rst clears ERROR to FETCH.

Source files
------------

// File: rtl/alu_types.sv
// ALU operation encoding shared by the controller and the datapath ALU.
package alu_types;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_control_t;

endpackage

// File: rtl/rv32i_defines.sv
// Shared definitions for the multicycle rv32i core: FSM states, datapath mux
// selects and the opcode / funct field values the controller decodes.
package rv32i_defines;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE_R = 4'd6,
        S_EXECUTE_I = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LUI       = 4'd12,
        S_AUIPC     = 4'd13,
        S_ERROR     = 4'd14
    } state_t;

    typedef enum logic {
        MEM_SRC_PC     = 1'b0,
        MEM_SRC_RESULT = 1'b1
    } mem_src_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'd0,
        SRC_A_OLD_PC = 2'd1,
        SRC_A_REG    = 2'd2,
        SRC_A_ZERO   = 2'd3
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_REG  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } src_b_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT    = 2'd0,
        RES_MEM_DATA   = 2'd1,
        RES_ALU_DIRECT = 2'd2
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_t;

    // Which instruction class the ALU decoder should interpret funct fields for.
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_R      = 2'd1,
        CLS_I      = 2'd2,
        CLS_BRANCH = 2'd3
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Combinational ALU decoder: maps instruction class plus funct3/funct7 to an
// ALU operation, and flags funct combinations that are not part of rv32i.
module rv32i_alu_decoder
    import alu_types::*;
    import rv32i_defines::*;
(
    input  logic [1:0]   alu_class,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output alu_control_t alu_control,
    output logic         illegal
);

    // Decode funct fields per class; anything outside rv32i raises illegal.
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_class)
            CLS_R: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  alu_control = ALU_ADD;
                        F3_SLL:  alu_control = ALU_SLL;
                        F3_SLT:  alu_control = ALU_SLT;
                        F3_SLTU: alu_control = ALU_SLTU;
                        F3_XOR:  alu_control = ALU_XOR;
                        F3_SR:   alu_control = ALU_SRL;
                        F3_OR:   alu_control = ALU_OR;
                        default: alu_control = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    alu_control = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    alu_control = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            CLS_I: begin
                case (funct3)
                    F3_ADD:  alu_control = ALU_ADD;
                    F3_SLT:  alu_control = ALU_SLT;
                    F3_SLTU: alu_control = ALU_SLTU;
                    F3_XOR:  alu_control = ALU_XOR;
                    F3_OR:   alu_control = ALU_OR;
                    F3_AND:  alu_control = ALU_AND;
                    F3_SLL: begin
                        // funct7 only carries meaning for the shift immediates
                        if (funct7 == F7_BASE) alu_control = ALU_SLL;
                        else                   illegal     = 1'b1;
                    end
                    default: begin
                        if (funct7 == F7_BASE)     alu_control = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_control = ALU_SRA;
                        else                       illegal     = 1'b1;
                    end
                endcase
            end
            CLS_BRANCH: begin
                case (funct3)
                    F3_BEQ, F3_BNE:   alu_control = ALU_SUB;
                    F3_BLT, F3_BGE:   alu_control = ALU_SLT;
                    F3_BLTU, F3_BGEU: alu_control = ALU_SLTU;
                    default:          illegal     = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// Main control FSM of the multicycle rv32i core. Sequences the shared ALU,
// memory port, PC/PC_old, IR and register file; holds no datapath state.
//
// state       | meaning
// ------------+-------------------------------------------------------
// FETCH       | read instr at PC into IR, PC <= PC + 4
// DECODE      | precompute branch/jump target OLD_PC + imm into ALU_OUT
// MEM_ADR     | compute load/store address rs1 + imm
// MEM_READ    | read memory at ALU_OUT
// MEM_WB      | write load data to rd
// MEM_WRITE   | write rs2 to memory at ALU_OUT
// EXECUTE_R   | rs1 op rs2
// EXECUTE_I   | rs1 op imm
// ALU_WB      | write ALU_OUT to rd
// BRANCH      | compare rs1/rs2, load PC with target when taken
// JAL         | PC <= target in ALU_OUT, ALU computes link OLD_PC + 4
// JALR        | target rs1 + imm into ALU_OUT
// LUI         | 0 + U-imm
// AUIPC       | OLD_PC + U-imm
// ERROR       | illegal instruction; absorbing until reset
module rv32i_multicycle_controller
    import alu_types::*;
    import rv32i_defines::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic         alu_zero,
    output logic         pc_ena,
    output logic         ir_write,
    output logic         mem_wr_ena,
    output logic         reg_write,
    output logic         mem_src,
    output logic [1:0]   alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [1:0]   result_src,
    output logic [2:0]   imm_src,
    output alu_control_t alu_control,
    output logic         illegal,
    output logic [3:0]   state
);

    state_t     state_q;
    state_t     state_d;
    logic       illegal_q;
    alu_class_t alu_class;
    logic       dec_illegal;
    logic       branch_taken;
    logic       pc_ena_raw;
    logic       ir_write_raw;
    logic       mem_wr_raw;
    logic       reg_write_raw;
    logic       wr_allowed;

    rv32i_alu_decoder u_alu_decoder (
        .alu_class   (alu_class),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (alu_control),
        .illegal     (dec_illegal)
    );

    // State register and sticky illegal flag; ena low freezes both.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            if (state_d == S_ERROR) illegal_q <= 1'b1;
        end
    end

    // Branch condition from the zero flag of SUB/SLT/SLTU.
    always_comb begin
        case (funct3)
            F3_BEQ, F3_BGE, F3_BGEU: branch_taken = alu_zero;
            default:                 branch_taken = ~alu_zero;
        endcase
    end

    // Next-state and Moore control decode.
    always_comb begin
        state_d       = state_q;
        pc_ena_raw    = 1'b0;
        ir_write_raw  = 1'b0;
        mem_wr_raw    = 1'b0;
        reg_write_raw = 1'b0;
        mem_src       = MEM_SRC_PC;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_FOUR;
        result_src    = RES_ALU_OUT;
        imm_src       = IMM_I;
        alu_class     = CLS_NONE;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_ena_raw   = 1'b1;
                result_src   = RES_ALU_DIRECT;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_RTYPE:          state_d = S_EXECUTE_R;
                    OP_ITYPE:          state_d = S_EXECUTE_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_ERROR;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                if (op == OP_STORE) begin
                    imm_src = IMM_S;
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                mem_src = MEM_SRC_RESULT;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src    = RES_MEM_DATA;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_src    = MEM_SRC_RESULT;
                mem_wr_raw = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTE_R: begin
                alu_class = CLS_R;
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                state_d   = dec_illegal ? S_ERROR : S_ALU_WB;
            end
            S_EXECUTE_I: begin
                alu_class = CLS_I;
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                state_d   = dec_illegal ? S_ERROR : S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_class  = CLS_BRANCH;
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_REG;
                pc_ena_raw = branch_taken & ~dec_illegal;
                state_d    = dec_illegal ? S_ERROR : S_FETCH;
            end
            S_JALR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                state_d   = S_JAL;
            end
            S_JAL: begin
                // PC takes the target held in ALU_OUT while the ALU forms the link value
                pc_ena_raw = 1'b1;
                alu_src_a  = SRC_A_OLD_PC;
                state_d    = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALU_WB;
            end
            default: state_d = S_ERROR;
        endcase
    end

    // No architectural write may happen while held in reset or frozen.
    assign wr_allowed = ena & ~rst;
    assign pc_ena     = pc_ena_raw & wr_allowed;
    assign ir_write   = ir_write_raw & wr_allowed;
    assign mem_wr_ena = mem_wr_raw & wr_allowed;
    assign reg_write  = reg_write_raw & wr_allowed;
    assign illegal    = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Directed bench for the multicycle controller: walks each instruction class
// through its states and checks controls against hand-derived values.
module tb_rv32i_multicycle_controller;
    import alu_types::*;
    import rv32i_defines::*;

    logic         clk;
    logic         rst;
    logic         ena;
    logic [6:0]   op;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic         alu_zero;
    logic         pc_ena;
    logic         ir_write;
    logic         mem_wr_ena;
    logic         reg_write;
    logic         mem_src;
    logic [1:0]   alu_src_a;
    logic [1:0]   alu_src_b;
    logic [1:0]   result_src;
    logic [2:0]   imm_src;
    alu_control_t alu_control;
    logic         illegal;
    logic [3:0]   state;

    int n_cmp = 0;
    int n_bad = 0;

    rv32i_multicycle_controller dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_zero    (alu_zero),
        .pc_ena      (pc_ena),
        .ir_write    (ir_write),
        .mem_wr_ena  (mem_wr_ena),
        .reg_write   (reg_write),
        .mem_src     (mem_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .illegal     (illegal),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_en(input string tag, input logic [3:0] st, input logic pc,
                          input logic irw, input logic mw, input logic rw);
        check_val({tag, ".state"}, {28'd0, state}, {28'd0, st});
        check_val({tag, ".pc_ena"}, {31'd0, pc_ena}, {31'd0, pc});
        check_val({tag, ".ir_write"}, {31'd0, ir_write}, {31'd0, irw});
        check_val({tag, ".mem_wr_ena"}, {31'd0, mem_wr_ena}, {31'd0, mw});
        check_val({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, rw});
    endtask

    task automatic set_ir(input logic [31:0] w);
        op     = w[6:0];
        funct3 = w[14:12];
        funct7 = w[31:25];
    endtask

    // one clock: past the rising edge, sample just after the falling edge
    task automatic adv();
        @(negedge clk);
        #1;
    endtask

    // load a new instruction while sitting in FETCH and check the fetch controls
    task automatic start(input string tag, input logic [31:0] w);
        set_ir(w);
        #1;
        chk_en({tag, ".fetch"}, S_FETCH, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val({tag, ".fetch.res"}, {30'd0, result_src}, {30'd0, RES_ALU_DIRECT});
    endtask

    initial begin
        rst      = 1'b1;
        ena      = 1'b1;
        alu_zero = 1'b0;
        set_ir(32'h0);

        adv();
        chk_en("rst0", S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst0.illegal", {31'd0, illegal}, 32'd0);
        adv();
        chk_en("rst1", S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // addi x1,x0,7
        start("addi", 32'h00700093);
        adv();
        chk_en("addi.dec", S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("addi.dec.a", {30'd0, alu_src_a}, {30'd0, SRC_A_OLD_PC});
        check_val("addi.dec.b", {30'd0, alu_src_b}, {30'd0, SRC_B_IMM});
        check_val("addi.dec.imm", {29'd0, imm_src}, {29'd0, IMM_B});
        adv();
        chk_en("addi.ex", S_EXECUTE_I, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("addi.ex.alu", {28'd0, alu_control}, {28'd0, ALU_ADD});
        check_val("addi.ex.a", {30'd0, alu_src_a}, {30'd0, SRC_A_REG});
        check_val("addi.ex.b", {30'd0, alu_src_b}, {30'd0, SRC_B_IMM});
        adv();
        chk_en("addi.wb", S_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("addi.wb.res", {30'd0, result_src}, {30'd0, RES_ALU_OUT});
        adv();

        // add x3,x1,x2
        start("add", 32'h002081B3);
        adv(); adv();
        chk_en("add.ex", S_EXECUTE_R, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("add.ex.a", {30'd0, alu_src_a}, {30'd0, SRC_A_REG});
        check_val("add.ex.b", {30'd0, alu_src_b}, {30'd0, SRC_B_REG});
        check_val("add.ex.alu", {28'd0, alu_control}, {28'd0, ALU_ADD});
        adv();
        chk_en("add.wb", S_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b1);
        adv();

        // sub x3,x1,x2
        start("sub", 32'h402081B3);
        adv(); adv();
        check_val("sub.ex.alu", {28'd0, alu_control}, {28'd0, ALU_SUB});
        adv();
        chk_en("sub.wb", S_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b1);
        adv();

        // srai x1,x1,2
        start("srai", 32'h4020D093);
        adv(); adv();
        chk_en("srai.ex", S_EXECUTE_I, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("srai.ex.alu", {28'd0, alu_control}, {28'd0, ALU_SRA});
        adv();
        chk_en("srai.wb", S_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b1);
        adv();

        // funct7=0x01 on an R-type is not rv32i
        start("rbad", 32'h022081B3);
        adv(); adv();
        chk_en("rbad.ex", S_EXECUTE_R, 1'b0, 1'b0, 1'b0, 1'b0);
        adv();
        chk_en("rbad.err", S_ERROR, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rbad.illegal", {31'd0, illegal}, 32'd1);
        adv();
        chk_en("rbad.hold", S_ERROR, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        adv();
        chk_en("rbad.rst", S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rbad.rst.illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;

        // lw x4,8(x0)
        start("lw", 32'h00802203);
        adv(); adv();
        chk_en("lw.adr", S_MEM_ADR, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("lw.adr.a", {30'd0, alu_src_a}, {30'd0, SRC_A_REG});
        check_val("lw.adr.imm", {29'd0, imm_src}, {29'd0, IMM_I});
        adv();
        chk_en("lw.rd", S_MEM_READ, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("lw.rd.msrc", {31'd0, mem_src}, 32'd1);
        adv();
        chk_en("lw.wb", S_MEM_WB, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("lw.wb.res", {30'd0, result_src}, {30'd0, RES_MEM_DATA});
        adv();

        // sw x1,12(x0)
        start("sw", 32'h00102623);
        adv(); adv();
        chk_en("sw.adr", S_MEM_ADR, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("sw.adr.imm", {29'd0, imm_src}, {29'd0, IMM_S});
        adv();
        chk_en("sw.wr", S_MEM_WRITE, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("sw.wr.msrc", {31'd0, mem_src}, 32'd1);
        adv();

        // beq x0,x0,8 taken
        alu_zero = 1'b1;
        start("beq1", 32'h00000463);
        adv();
        check_val("beq1.dec.imm", {29'd0, imm_src}, {29'd0, IMM_B});
        adv();
        chk_en("beq1.br", S_BRANCH, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("beq1.br.alu", {28'd0, alu_control}, {28'd0, ALU_SUB});
        check_val("beq1.br.b", {30'd0, alu_src_b}, {30'd0, SRC_B_REG});
        adv();

        // beq not taken
        alu_zero = 1'b0;
        start("beq0", 32'h00000463);
        adv(); adv();
        chk_en("beq0.br", S_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0);
        adv();

        // blt taken when slt result non-zero
        start("blt", 32'h00004463);
        adv(); adv();
        chk_en("blt.br", S_BRANCH, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("blt.br.alu", {28'd0, alu_control}, {28'd0, ALU_SLT});
        adv();

        // bgeu not taken when sltu result non-zero
        start("bgeu", 32'h00007463);
        adv(); adv();
        chk_en("bgeu.br", S_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("bgeu.br.alu", {28'd0, alu_control}, {28'd0, ALU_SLTU});
        adv();

        // jal x1,8
        start("jal", 32'h008000EF);
        adv();
        check_val("jal.dec.imm", {29'd0, imm_src}, {29'd0, IMM_J});
        adv();
        chk_en("jal.j", S_JAL, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("jal.j.a", {30'd0, alu_src_a}, {30'd0, SRC_A_OLD_PC});
        check_val("jal.j.b", {30'd0, alu_src_b}, {30'd0, SRC_B_FOUR});
        check_val("jal.j.res", {30'd0, result_src}, {30'd0, RES_ALU_OUT});
        adv();
        chk_en("jal.wb", S_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b1);
        adv();

        // jalr x1,0(x1)
        start("jalr", 32'h000080E7);
        adv(); adv();
        chk_en("jalr.t", S_JALR, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("jalr.t.a", {30'd0, alu_src_a}, {30'd0, SRC_A_REG});
        check_val("jalr.t.b", {30'd0, alu_src_b}, {30'd0, SRC_B_IMM});
        adv();
        chk_en("jalr.j", S_JAL, 1'b1, 1'b0, 1'b0, 1'b0);
        adv();
        chk_en("jalr.wb", S_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b1);
        adv();

        // lui x1,0x12345
        start("lui", 32'h123450B7);
        adv(); adv();
        chk_en("lui.ex", S_LUI, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("lui.a", {30'd0, alu_src_a}, {30'd0, SRC_A_ZERO});
        check_val("lui.imm", {29'd0, imm_src}, {29'd0, IMM_U});
        adv();
        chk_en("lui.wb", S_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b1);
        adv();

        // auipc x1,1
        start("auipc", 32'h00001097);
        adv(); adv();
        chk_en("auipc.ex", S_AUIPC, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("auipc.a", {30'd0, alu_src_a}, {30'd0, SRC_A_OLD_PC});
        adv();
        chk_en("auipc.wb", S_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b1);
        adv();

        // freeze in EXECUTE_R and ALU_WB
        start("frz", 32'h002081B3);
        adv(); adv();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            adv();
            chk_en($sformatf("frz.ex%0d", i), S_EXECUTE_R, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        ena = 1'b1;
        adv();
        chk_en("frz.wb", S_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b1);
        ena = 1'b0;
        #1;
        check_val("frz.wb.off", {31'd0, reg_write}, 32'd0);
        adv();
        chk_en("frz.wb.hold", S_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b0);
        ena = 1'b1;
        adv();

        // undefined opcode 0x7F
        start("op7f", 32'h0000007F);
        adv();
        chk_en("op7f.dec", S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
        adv();
        chk_en("op7f.err", S_ERROR, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("op7f.illegal", {31'd0, illegal}, 32'd1);
        rst = 1'b1;
        adv();
        chk_en("op7f.rst", S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("op7f.rst.illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;

        // reset during the store strobe suppresses the write
        start("swrst", 32'h00102623);
        adv(); adv(); adv();
        chk_en("swrst.wr", S_MEM_WRITE, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check_val("swrst.wr.off", {31'd0, mem_wr_ena}, 32'd0);
        adv();
        chk_en("swrst.rst", S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        start("post", 32'h00700093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
